// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day display path: field width, segment
// patterns, digit positions, conversion FSM states and the double-dabble step.
package clock_pkg;

  localparam int TIME_W = 6;
  localparam int DIGITS = 6;
  localparam int BCD_W  = 8;
  localparam int DD_W   = BCD_W + TIME_W;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active high
  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_1   = 7'b0000110;
  localparam logic [6:0] SEG_2   = 7'b1011011;
  localparam logic [6:0] SEG_3   = 7'b1001111;
  localparam logic [6:0] SEG_4   = 7'b1100110;
  localparam logic [6:0] SEG_5   = 7'b1101101;
  localparam logic [6:0] SEG_6   = 7'b1111101;
  localparam logic [6:0] SEG_7   = 7'b0000111;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1101111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  localparam logic [2:0] DIG_SEC_U = 3'd0;
  localparam logic [2:0] DIG_SEC_T = 3'd1;
  localparam logic [2:0] DIG_MIN_U = 3'd2;
  localparam logic [2:0] DIG_MIN_T = 3'd3;
  localparam logic [2:0] DIG_HRS_U = 3'd4;
  localparam logic [2:0] DIG_HRS_T = 3'd5;

  // One conversion step per binary bit; the last step index commits digits
  localparam logic [2:0] LAST_STEP = 3'(TIME_W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_t;

  // One double-dabble step on {tens, units, binary}: correct nibbles >= 5,
  // then shift the whole register left by one.
  function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] r);
    logic [DD_W-1:0] t;
    t = r;
    if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
    if (t[9:6] >= 4'd5)   t[9:6]   = t[9:6] + 4'd3;
    return {t[DD_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment pattern; non-decimal codes blank the digit.
module seg7_decode
  import clock_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/clock_display.sv
// Samples the time-of-day counter, converts each field to BCD with a sequential
// double-dabble engine and scans six multiplexed 7-segment digits.
module clock_display
  import clock_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TIME_W-1:0] count_sec,
  input  logic [TIME_W-1:0] count_min,
  input  logic [TIME_W-1:0] count_hrs,
  output logic [5:0]        digit_en,
  output logic [6:0]        seg,
  output logic              busy,
  output logic              dbg_state
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_RELOAD = PW'(SCAN_DIV - 1);

  conv_state_t           state;
  logic [3*TIME_W-1:0]   snapshot;
  logic [3*TIME_W-1:0]   live;
  logic [DD_W-1:0]       sr_sec, sr_min, sr_hrs;
  logic [DD_W-1:0]       nx_sec, nx_min, nx_hrs;
  logic [2:0]            step;
  logic [3:0]            digits [DIGITS];

  logic [PW-1:0]         presc;
  logic [2:0]            idx;
  logic [2:0]            idx_nx;
  logic [6:0]            seg_nx;

  assign live      = {count_hrs, count_min, count_sec};
  assign nx_sec    = dd_step(sr_sec);
  assign nx_min    = dd_step(sr_min);
  assign nx_hrs    = dd_step(sr_hrs);
  assign dbg_state = state;

  // Conversion FSM: inputs are only looked at in IDLE, so changes during
  // CONV are picked up by the compare on the first IDLE edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      snapshot <= '0;
      sr_sec   <= '0;
      sr_min   <= '0;
      sr_hrs   <= '0;
      step     <= '0;
      busy     <= 1'b0;
      for (int i = 0; i < DIGITS; i++) digits[i] <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (live != snapshot) begin
            snapshot <= live;
            sr_sec   <= {{BCD_W{1'b0}}, count_sec};
            sr_min   <= {{BCD_W{1'b0}}, count_min};
            sr_hrs   <= {{BCD_W{1'b0}}, count_hrs};
            step     <= '0;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          sr_sec <= nx_sec;
          sr_min <= nx_min;
          sr_hrs <= nx_hrs;
          step   <= step + 3'd1;
          if (step == LAST_STEP) begin
            digits[DIG_SEC_U] <= nx_sec[9:6];
            digits[DIG_SEC_T] <= nx_sec[13:10];
            digits[DIG_MIN_U] <= nx_min[9:6];
            digits[DIG_MIN_T] <= nx_min[13:10];
            digits[DIG_HRS_U] <= nx_hrs[9:6];
            digits[DIG_HRS_T] <= nx_hrs[13:10];
            busy              <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    idx_nx = idx;
    if (presc == '0) idx_nx = (idx == DIG_HRS_T) ? DIG_SEC_U : idx + 3'd1;
  end

  seg7_decode u_dec (
    .bcd (digits[idx_nx]),
    .seg (seg_nx)
  );

  // Scan runs free of the FSM; enable and segments share the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc    <= PRE_RELOAD;
      idx      <= DIG_SEC_U;
      digit_en <= 6'b000001;
      seg      <= SEG_0;
    end else begin
      presc    <= (presc == '0) ? PRE_RELOAD : presc - PW'(1);
      idx      <= idx_nx;
      digit_en <= 6'b000001 << idx_nx;
      seg      <= seg_nx;
    end
  end

endmodule

// File: tb/tb_clock_display.sv
// Randomized scoreboard bench for clock_display with a cycle-arithmetic
// reference model of capture timing, scan position and displayed digits.
module tb_clock_display;

  localparam int SCAN_DIV = 4;

  logic       clk;
  logic       rst_n;
  logic [5:0] count_sec, count_min, count_hrs;
  logic [5:0] digit_en;
  logic [6:0] seg;
  logic       busy;
  logic       dbg_state;

  int total = 0;
  int bad   = 0;

  // Model state: k counts rising edges since reset release
  int              k      = 0;
  int              free_k = 0;
  int              end_k  = 0;
  logic [17:0]     snap   = '0;
  logic [23:0]     exp_q[$];
  logic [23:0]     disp_model = '0;
  logic            busy_prev  = 1'b0;

  clock_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .count_sec (count_sec),
    .count_min (count_min),
    .count_hrs (count_hrs),
    .digit_en  (digit_en),
    .seg       (seg),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
            7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    return (d < 4'd10) ? tbl[d] : 7'b0000000;
  endfunction

  function automatic logic [23:0] to_digits(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A capture happens on any edge where the block is free (7 edges after the
  // previous capture) and the inputs differ from the last captured value.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k      = 0;
      free_k = 0;
      end_k  = 0;
      snap   = '0;
      exp_q.delete();
    end else begin
      k++;
      if (k >= free_k && {count_hrs, count_min, count_sec} != snap) begin
        snap   = {count_hrs, count_min, count_sec};
        exp_q.push_back(to_digits(int'(count_hrs), int'(count_min), int'(count_sec)));
        free_k = k + 7;
        end_k  = k + 6;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_digit_en", 32'(digit_en), 32'h01);
      chk("rst_seg", 32'(seg), 32'(7'b0111111));
      chk("rst_busy", 32'(busy), 32'h0);
      disp_model = '0;
      busy_prev  = 1'b0;
    end else begin
      automatic int idx = (k / SCAN_DIV) % 6;
      chk("digit_en", 32'(digit_en), 32'(6'b000001 << idx));
      chk("seg", 32'(seg), 32'(seg_ref(disp_model[4*idx +: 4])));
      chk("busy", 32'(busy), 32'(k < end_k));
      if (busy_prev && !busy) begin
        if (exp_q.size() == 0) chk("scoreboard_pop", 32'h0, 32'h1);
        else disp_model = exp_q.pop_front();
      end
      busy_prev = busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input int h, input int m, input int s);
    count_hrs = 6'(h);
    count_min = 6'(m);
    count_sec = 6'(s);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0);
    wait_cycles(3);
    rst_n = 1'b1;

    // Idle with zero inputs: a full scan frame plus change, no conversion
    wait_cycles(30);

    drive(23, 59, 59);
    wait_cycles(30);

    // Mid-conversion change is ignored, then recaptured on the first free edge
    drive(1, 2, 3);
    wait_cycles(30);
    drive(23, 59, 59);
    wait_cycles(2);
    drive(0, 0, 0);
    wait_cycles(40);

    drive(63, 63, 63);
    wait_cycles(30);

    // Reset pulse during a conversion, then recapture after release
    drive(12, 34, 56);
    wait_cycles(3);
    rst_n = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(30);

    // Random traffic with short and long holds
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0)
        drive(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 63)));
      wait_cycles(int'($urandom_range(1, 12)));
      if ($urandom_range(0, 29) == 0) begin
        rst_n = 1'b0;
        wait_cycles(1);
        rst_n = 1'b1;
      end
    end
    wait_cycles(40);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
